// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD1602 4-bit interface.
//   lcd_state_e  - state encoding of lcd_nibble_driver
//   HD44780 command constants used by the command/character sequencer
//   is_long_cmd  - true for commands whose execution needs the long wait
`timescale 1ns/1ps
package lcd_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StSetupH,
    StPulseH,
    StHoldH,
    StGap,
    StSetupL,
    StPulseL,
    StHoldL,
    StWait
  } lcd_state_e;

  localparam logic [7:0] CLEAR_DISPLAY      = 8'h01;
  localparam logic [7:0] RETURN_HOME        = 8'h02;
  localparam logic [7:0] ENTRY_MODE         = 8'h06;
  localparam logic [7:0] DISPON_CURSOROFF   = 8'h0C;
  localparam logic [7:0] FUNCSET_4BIT_2LINE = 8'h28;
  localparam logic [7:0] SET_DDRAM          = 8'h80;
  localparam logic [7:0] SET_CGRAM          = 8'h40;

  // Clear and home (bit 0 of home is don't-care, so 0x03 is home as well).
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CLEAR_DISPLAY) || (data == RETURN_HOME) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down-counter shared by every timed state.
//   clk, reset - clock, asynchronous active-low reset
//   load       - load 'value' into the counter this cycle
//   value      - value to load (state duration minus one)
//   zero       - counter has reached zero
// The counter stops at zero; it never wraps.
`timescale 1ns/1ps
module lcd_delay_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] value,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_driver.sv
// lcd_nibble_driver: LCD1602 4-bit physical interface stage.
// Accepts one {rs, data} byte per valid/ready handshake, sends the high then
// the low nibble with programmable E setup/width/hold, then waits the
// controller execution time before becoming ready again.
//   clk, reset            - clock, asynchronous active-low reset
//   wr_valid_i/wr_ready_o - write handshake (accept when both high)
//   wr_rs_i, wr_data_i    - register select and byte
//   wr_nibble_only_i      - send only wr_data_i[7:4] (wake-up sequence)
//   lcd_rs/lcd_rw/lcd_en/lcd_d - LCD pins (D7..D4), registered
//   busy_o                - inverse of wr_ready_o
// Optional macro LCD_LONG_CMD_EN: clear/home commands use LONG_WAIT_CYC.
`timescale 1ns/1ps
module lcd_nibble_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned PULSE_CYC      = 25,
  parameter int unsigned HOLD_CYC       = 1,
  parameter int unsigned GAP_CYC        = 50,
  parameter int unsigned SHORT_WAIT_CYC = 2000,
  parameter int unsigned LONG_WAIT_CYC  = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_nibble_only_i,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [3:0] lcd_d,
  output logic       busy_o
);

  localparam int unsigned Max1   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned Max2   = (Max1 > HOLD_CYC) ? Max1 : HOLD_CYC;
  localparam int unsigned Max3   = (Max2 > GAP_CYC) ? Max2 : GAP_CYC;
  localparam int unsigned Max4   = (Max3 > SHORT_WAIT_CYC) ? Max3 : SHORT_WAIT_CYC;
  localparam int unsigned MaxCyc = (Max4 > LONG_WAIT_CYC) ? Max4 : LONG_WAIT_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLd   = CntW'(GAP_CYC - 1);
  localparam logic [CntW-1:0] ShortLd = CntW'(SHORT_WAIT_CYC - 1);

  lcd_state_e state_q, state_d;

  logic            rs_q, nib_q;
  logic [7:0]      data_q;
  logic            accept;
  logic            cnt_load, cnt_zero;
  logic [CntW-1:0] cnt_value, wait_ld;
  logic            en_q, rs_out_q;
  logic [3:0]      d_q;

`ifdef LCD_LONG_CMD_EN
  localparam logic [CntW-1:0] LongLd = CntW'(LONG_WAIT_CYC - 1);
  assign wait_ld = (!nib_q && is_long_cmd(rs_q, data_q)) ? LongLd : ShortLd;
`else
  assign wait_ld = ShortLd;
`endif

  lcd_delay_counter #(
    .Width (CntW)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  // Every transition into a timed state loads that state's duration minus one.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cnt_load  = 1'b0;
    cnt_value = '0;
    unique case (state_q)
      StIdle: begin
        if (wr_valid_i) begin
          accept    = 1'b1;
          state_d   = StSetupH;
          cnt_load  = 1'b1;
          cnt_value = SetupLd;
        end
      end
      StSetupH: if (cnt_zero) begin
        state_d = StPulseH; cnt_load = 1'b1; cnt_value = PulseLd;
      end
      StPulseH: if (cnt_zero) begin
        state_d = StHoldH; cnt_load = 1'b1; cnt_value = HoldLd;
      end
      StHoldH: if (cnt_zero) begin
        cnt_load = 1'b1;
        if (nib_q) begin
          state_d = StWait; cnt_value = wait_ld;
        end else begin
          state_d = StGap; cnt_value = GapLd;
        end
      end
      StGap: if (cnt_zero) begin
        state_d = StSetupL; cnt_load = 1'b1; cnt_value = SetupLd;
      end
      StSetupL: if (cnt_zero) begin
        state_d = StPulseL; cnt_load = 1'b1; cnt_value = PulseLd;
      end
      StPulseL: if (cnt_zero) begin
        state_d = StHoldL; cnt_load = 1'b1; cnt_value = HoldLd;
      end
      StHoldL: if (cnt_zero) begin
        state_d = StWait; cnt_load = 1'b1; cnt_value = wait_ld;
      end
      StWait: if (cnt_zero) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs_q   <= wr_rs_i;
        nib_q  <= wr_nibble_only_i;
        data_q <= wr_data_i;
      end
    end
  end

  // Pins are registered from the current state, so they trail it by one cycle;
  // rs and d hold their last value through WAIT and IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q     <= 1'b0;
      rs_out_q <= 1'b0;
      d_q      <= 4'h0;
    end else begin
      en_q <= (state_q == StPulseH) || (state_q == StPulseL);
      case (state_q)
        StSetupH, StPulseH, StHoldH, StGap: begin
          d_q      <= data_q[7:4];
          rs_out_q <= rs_q;
        end
        StSetupL, StPulseL, StHoldL: begin
          d_q      <= data_q[3:0];
          rs_out_q <= rs_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign wr_ready_o = (state_q == StIdle);
  assign busy_o     = ~wr_ready_o;
  assign lcd_en     = en_q;
  assign lcd_rs     = rs_out_q;
  assign lcd_d      = d_q;
  assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
`timescale 1ns/1ps
module tb_lcd_nibble_driver;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int G  = 3;
  localparam int SW = 4;
  localparam int LW = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic       wr_nib = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, lcd_rs, lcd_rw, lcd_en, busy;
  logic [3:0] lcd_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lcd_nibble_driver #(
    .SETUP_CYC      (S),
    .PULSE_CYC      (P),
    .HOLD_CYC       (H),
    .GAP_CYC        (G),
    .SHORT_WAIT_CYC (SW),
    .LONG_WAIT_CYC  (LW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_valid_i       (wr_valid),
    .wr_ready_o       (wr_ready),
    .wr_rs_i          (wr_rs),
    .wr_data_i        (wr_data),
    .wr_nibble_only_i (wr_nib),
    .lcd_rs           (lcd_rs),
    .lcd_rw           (lcd_rw),
    .lcd_en           (lcd_en),
    .lcd_d            (lcd_d),
    .busy_o           (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A write occupies a fixed window of edges after its accept edge (k = 0);
  // pin values are a function of k only.
  bit         m_busy = 0;
  int         m_k = 0, m_len = 0;
  logic       m_rs_l = 0, m_nib_l = 0;
  logic [7:0] m_data_l = 0;
  logic       m_en = 0, m_rs = 0;
  logic [3:0] m_d = 0;
  logic       prev_en = 0;
  int         e_count = 0;

  function automatic int busy_len(input logic rs, input logic [7:0] data, input logic nib);
    int w = SW;
`ifdef LCD_LONG_CMD_EN
    if (!nib && !rs && data >= 8'h01 && data <= 8'h03) w = LW;
`endif
    return nib ? (S + P + H + w) : (2 * (S + P + H) + G + w);
  endfunction

  always @(posedge clk) begin
    int hi_end, lo_start;
    if (!reset) begin
      m_busy = 0; m_en = 0; m_rs = 0; m_d = 0; prev_en = 0;
    end else if (m_busy) begin
      m_k++;
      hi_end   = m_nib_l ? (S + P + H) : (S + P + H + G);
      lo_start = S + P + H + G + 1;
      m_en = (m_k >= S + 1 && m_k <= S + P) ||
             (!m_nib_l && m_k >= lo_start + S && m_k < lo_start + S + P);
      if (m_k >= 1 && m_k <= hi_end) begin
        m_d = m_data_l[7:4]; m_rs = m_rs_l;
      end else if (!m_nib_l && m_k >= lo_start && m_k <= lo_start + S + P + H - 1) begin
        m_d = m_data_l[3:0]; m_rs = m_rs_l;
      end
      if (m_k >= m_len) m_busy = 0;
    end else begin
      m_en = 0;
      if (wr_valid) begin
        m_busy = 1; m_k = 0;
        m_rs_l = wr_rs; m_nib_l = wr_nib; m_data_l = wr_data;
        m_len = busy_len(wr_rs, wr_data, wr_nib);
      end
    end
    #1;
    if (reset) begin
      check("ready", int'(wr_ready), int'(!m_busy));
      check("busy", int'(busy), int'(m_busy));
      check("rw", int'(lcd_rw), 0);
      check("en", int'(lcd_en), int'(m_en));
      check("d", int'(lcd_d), int'(m_d));
      check("rs", int'(lcd_rs), int'(m_rs));
      if (lcd_en && !prev_en) e_count++;
      prev_en = lcd_en;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input string name);
    int guard = 0;
    while (!wr_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!wr_ready) check(name, int'(wr_ready), 1);
  endtask

  // Called at a negedge; returns at the negedge where ready has come back.
  task automatic do_write(input logic rs, input logic [7:0] data, input logic nib,
                          output int low, output int rise);
    low = -1; rise = -1;
    wait_ready("pre_write_timeout");
    wr_valid = 1; wr_rs = rs; wr_data = data; wr_nib = nib;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 0; wr_rs = ~rs; wr_data = ~data; wr_nib = ~nib;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      if (lcd_en && rise < 0) rise = c;
      if (wr_ready) begin
        low = c;
        break;
      end
    end
    if (low < 0) check("write_timeout", int'(wr_ready), 1);
  endtask

  initial begin
    int low, rise, e0;

    #12;
    check("rst_en", int'(lcd_en), 0);
    check("rst_d", int'(lcd_d), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_ready", int'(wr_ready), 1);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Data byte 0x41
    e0 = e_count;
    do_write(1'b1, 8'h41, 1'b0, low, rise);
    check("byte_ready_low", low, 15);
    check("byte_e_rise", rise, 2);
    check("byte_pulses", e_count - e0, 2);

    // Nibble-only 0x30
    e0 = e_count;
    do_write(1'b0, 8'h30, 1'b1, low, rise);
    check("nib_ready_low", low, 8);
    check("nib_pulses", e_count - e0, 1);
    check("nib_d", int'(lcd_d), 3);

    // Clear display
    do_write(1'b0, 8'h01, 1'b0, low, rise);
`ifdef LCD_LONG_CMD_EN
    check("clear_ready_low", low, 21);
`else
    check("clear_ready_low", low, 15);
`endif

    // Write held valid while busy: second byte goes out once, after ready
    e0 = e_count;
    wr_valid = 1; wr_rs = 1; wr_data = 8'h41; wr_nib = 0;
    @(posedge clk);
    @(negedge clk);
    wr_data = 8'h55;
    wait_ready("busy_wait1");
    @(posedge clk);
    @(negedge clk);
    wr_valid = 0;
    check("busy_second_accept", int'(wr_ready), 0);
    wait_ready("busy_wait2");
    repeat (3) @(negedge clk);
    check("busy_no_requeue", int'(wr_ready), 1);
    check("busy_pulses", e_count - e0, 4);
    check("busy_last_d", int'(lcd_d), 5);

    // Reset during the low-nibble pulse
    wr_valid = 1; wr_rs = 1; wr_data = 8'h41; wr_nib = 0;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 0;
    repeat (9) @(negedge clk);
    check("pre_rst_en", int'(lcd_en), 1);
    #1 reset = 0;
    #1;
    check("mid_rst_en", int'(lcd_en), 0);
    check("mid_rst_d", int'(lcd_d), 0);
    check("mid_rst_rs", int'(lcd_rs), 0);
    check("mid_rst_ready", int'(wr_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    do_write(1'b1, 8'h41, 1'b0, low, rise);
    check("post_rst_ready_low", low, 15);

    // Back-to-back 0x28 then 0x0C
    e0 = e_count;
    wr_valid = 1; wr_rs = 0; wr_data = 8'h28; wr_nib = 0;
    @(posedge clk);
    @(negedge clk);
    wr_data = 8'h0C;
    wait_ready("b2b_wait1");
    @(posedge clk);
    @(negedge clk);
    wr_valid = 0;
    check("b2b_no_bubble", int'(wr_ready), 0);
    wait_ready("b2b_wait2");
    check("b2b_pulses", e_count - e0, 4);

    // Randomized traffic, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!reset) reset = 1;
      else if ($urandom_range(0, 299) == 0) reset = 0;
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_rs    = 1'($urandom);
      wr_nib   = ($urandom_range(0, 3) == 0);
      wr_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
    end
    @(negedge clk);
    reset = 1;
    wr_valid = 0;
    wait_ready("final_wait");
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_driver.md
# lcd_nibble_driver

Physical-interface stage for the LCD1602 in 4-bit mode. It accepts one byte write per handshake, consisting of an `rs` flag plus 8-bit data, from the LCD1602 command/character sequencer. It splits the byte into high and low nibbles, generates each `E` pulse with programmable setup, width and hold, and then waits the HD44780 execution time before accepting the next write. Single-nibble writes cover the 0x3/0x2 wake-up sequence used to enter 4-bit mode.

## Interface
Parameters:
- `SETUP_CYC`, default 2: cycles from data/rs valid to `E` rising (≥1).
- `PULSE_CYC`, default 25: `E` high cycles (≥1).
- `HOLD_CYC`, default 1: cycles data held after `E` falls (≥1).
- `GAP_CYC`, default 50: idle cycles between high and low nibble (≥1).
- `SHORT_WAIT_CYC`, default 2000: post-write execution wait, 40 µs at 50 MHz (≥1).
- `LONG_WAIT_CYC`, default 80000: post-write wait for clear/home, 1.6 ms at 50 MHz (≥1).

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `wr_valid_i`, in, 1: write request.
- `wr_ready_o`, out, 1: block idle; a write is accepted on an edge where valid and ready are both 1.
- `wr_rs_i`, in, 1: 0 = command, 1 = data.
- `wr_data_i`, in, 8: byte to send.
- `wr_nibble_only_i`, in, 1: send only `wr_data_i[7:4]` (one pulse).
- `lcd_rs`, out, 1: LCD RS pin.
- `lcd_rw`, out, 1: LCD RW pin, constant 0.
- `lcd_en`, out, 1: LCD E pin.
- `lcd_d`, out, 4: LCD D7..D4.
- `busy_o`, out, 1: inverse of `wr_ready_o`.

## Operation
- **Reset values:** state IDLE, `lcd_en` 0, `lcd_rs` 0, `lcd_rw` 0, `lcd_d` 0, `wr_ready_o` 1, `busy_o` 0, counter 0.
- **Reset asserted mid-operation:** every output returns to its reset value immediately (asynchronously), `E` included. The write in flight is dropped.
- **State machine:**
  - IDLE: on accept, latch rs, data and the nibble-only flag, and go to SETUP_H.
  - SETUP_H → PULSE_H → HOLD_H.
  - HOLD_H → WAIT if nibble-only, otherwise HOLD_H → GAP.
  - GAP → SETUP_L → PULSE_L → HOLD_L → WAIT → IDLE.
- **State durations:** each timed state lasts exactly its parameter in cycles. A single down-counter is loaded with (param−1) on state entry and the state exits when the counter reaches 0.
- **Outputs:** `lcd_rs`, `lcd_d` and `lcd_en` are registered.
  - `lcd_d` = data[7:4] from SETUP_H through GAP, and data[3:0] from SETUP_L through HOLD_L.
  - `lcd_d` keeps its last value in WAIT and IDLE.
  - `lcd_en` = 1 only in PULSE_H and PULSE_L.
- **Write acceptance:** `wr_ready_o` = 1 only in IDLE. `wr_valid_i` while busy is ignored and is not queued. Inputs are sampled only on the accept edge, so later changes have no effect.
- **WAIT length:** `SHORT_WAIT_CYC`, unless the long-command rule in Configuration applies.

## Timing
- The accept edge counts as cycle 0.
- `lcd_en` rises at cycle `SETUP_CYC`+1.
- **Full byte:** `wr_ready_o` is low for exactly SETUP+PULSE+HOLD+GAP+SETUP+PULSE+HOLD+WAIT cycles.
- **Nibble-only:** `wr_ready_o` is low for exactly SETUP+PULSE+HOLD+WAIT cycles.
- **Back-to-back writes:** a new write can be accepted on the first IDLE cycle. No extra bubble is inserted.
- **Counter width:** $clog2 of the largest parameter. There is no wrap-around, because the counter only counts down from a loaded value.

## Configuration
- **`LCD_LONG_CMD_EN` defined:** a command write (rs=0, data ∈ {0x01, 0x02, 0x03}, i.e. clear or home) uses `LONG_WAIT_CYC` for WAIT.
  - Nibble-only writes always use `SHORT_WAIT_CYC`.
- **`LCD_LONG_CMD_EN` not defined:** every write uses `SHORT_WAIT_CYC`, and `LONG_WAIT_CYC` is unused.

## Structure
- **Package `lcd_pkg`:**
  - state enum.
  - HD44780 command constants: CLEAR_DISPLAY 0x01, RETURN_HOME 0x02, ENTRY_MODE 0x06, DISPON_CURSOROFF 0x0C, FUNCSET_4BIT_2LINE 0x28, SET_DDRAM base 0x80, SET_CGRAM base 0x40.
  - the `is_long_cmd` function.
- **Sub-module `lcd_delay_counter`:** loadable down-counter with load, value and zero-flag ports, shared by every timed state.

## Test plan
Parameters for all tests: SETUP=1, PULSE=2, HOLD=1, GAP=3, SHORT=4, LONG=10.
- **Data byte:** rs=1, data 0x41 → `lcd_d` = 0x4 with `E` high for 2 cycles starting at cycle 2, then `lcd_d` = 0x1 with `E` high for 2 cycles; `lcd_rs` = 1 throughout; `wr_ready_o` low for 15 cycles.
- **Nibble-only:** rs=0, data 0x30 → a single `E` pulse with `lcd_d` = 0x3; ready low for 8 cycles.
- **Clear with `LCD_LONG_CMD_EN`:** rs=0, data 0x01 → ready low for 21 cycles; without the macro, ready low for 15 cycles.
- **Write while busy:** `wr_valid_i` held with data 0x55 during a 0x41 write → 0x55 is sent only after ready returns, and exactly once.
- **Reset mid-pulse:** `reset`=0 during PULSE_L → `lcd_en` = 0 in the same cycle, all outputs at reset values; the next write runs normally.
- **Back-to-back writes:** 0x28 then 0x0C on consecutive ready windows → 4 `E` pulses, with no cycle gap between the ready rise and the second accept.
